// File: rtl/mastermind_scorer_pkg.sv
// mm_pkg: shared constants and types for the Mastermind scorer slice.
//   NUM_PEGS   - pegs per code/guess (fixed at 4)
//   COLOR_W    - bits per peg colour
//   color_t    - one peg colour
//   score_t    - black/white peg count (0..4)
//   peg_mask_t - one bit per peg position
package mm_pkg;

  localparam int NUM_PEGS = 4;
  localparam int COLOR_W  = 3;

  typedef logic [COLOR_W-1:0]  color_t;
  typedef logic [2:0]          score_t;
  typedef logic [NUM_PEGS-1:0] peg_mask_t;

endpackage

// File: rtl/mastermind_scorer_peg_matcher.sv
// peg_matcher: combinational colour-only match search for one guess peg.
// Finds the lowest code position that is not an exact match, has not
// already been paired with an earlier guess peg, and holds the same colour
// as the guess peg being scored.
// Ports:
//   guess_color - colour of the guess peg being scored
//   code        - the four secret code colours
//   exact_mask  - positions where code and guess already match exactly
//   used_mask   - code positions already consumed by a white peg
//   found       - a pairable code position exists
//   match_sel   - one-hot select of that lowest position (0 when !found)
module peg_matcher
  import mm_pkg::*;
#(
  parameter int COLOR_W = mm_pkg::COLOR_W
) (
  input  logic [COLOR_W-1:0]               guess_color,
  input  logic [NUM_PEGS-1:0][COLOR_W-1:0] code,
  input  peg_mask_t                        exact_mask,
  input  peg_mask_t                        used_mask,
  output logic                             found,
  output peg_mask_t                        match_sel
);

  // Priority scan from position 0 upward; the first hit wins so the
  // white count comes out as sum(min(code count, guess count)) - black.
  always_comb begin
    found     = 1'b0;
    match_sel = '0;
    for (int j = 0; j < NUM_PEGS; j++) begin
      if (!found && !exact_mask[j] && !used_mask[j] && (code[j] == guess_color)) begin
        found        = 1'b1;
        match_sel[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mastermind_scorer.sv
// mastermind_scorer: datapath responder to the game controller's strobes.
// Captures code and guess pegs on level load strobes, scores one guess
// position per compare cycle, and publishes black/white counts plus sticky
// win / game-over status when the controller signals reach_result_4.
// Ports:
//   clk, reset        - single clock, synchronous active-high reset
//   peg_in            - colour from the switches
//   load_code_1..4    - write code slot 0..3 (ignored while a round is active)
//   load_guess_1..4   - write guess slot 0..3 (ignored while a round is active)
//   compare/compare_i - score guess position compare_i this cycle
//   reach_result_4    - round complete, publish the score
//   black, white      - last published exact / colour-only counts
//   result_valid      - one-cycle pulse when black/white update
//   win               - sticky, set when a published black equals 4
//   game_over         - win or guess_count reached MAX_GUESSES
//   guess_count       - rounds published since reset (saturating)
//   hint_exact        - exact mask captured at publish
//                       (only with MASTERMIND_SCORER_HINT_EN defined)
module mastermind_scorer
  import mm_pkg::*;
#(
  parameter int COLOR_W     = mm_pkg::COLOR_W,
  parameter int MAX_GUESSES = 10,
  parameter int CNT_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COLOR_W-1:0] peg_in,
  input  logic               load_code_1,
  input  logic               load_code_2,
  input  logic               load_code_3,
  input  logic               load_code_4,
  input  logic               load_guess_1,
  input  logic               load_guess_2,
  input  logic               load_guess_3,
  input  logic               load_guess_4,
  input  logic               compare,
  input  logic [1:0]         compare_i,
  input  logic               reach_result_4,
  output score_t             black,
  output score_t             white,
  output logic               result_valid,
  output logic               win,
  output logic               game_over,
  output logic [CNT_W-1:0]   guess_count
`ifdef MASTERMIND_SCORER_HINT_EN
  ,
  output peg_mask_t          hint_exact
`endif
);

  logic [NUM_PEGS-1:0][COLOR_W-1:0] code_q, code_d;
  logic [NUM_PEGS-1:0][COLOR_W-1:0] guess_q, guess_d;
  peg_mask_t          used_q, used_d;
  peg_mask_t          done_q, done_d;
  logic               round_active_q, round_active_d;
  score_t             acc_black_q, acc_black_d;
  score_t             acc_white_q, acc_white_d;
  score_t             black_q, black_d;
  score_t             white_q, white_d;
  logic               result_valid_q, result_valid_d;
  logic               win_q, win_d;
  logic [CNT_W-1:0]   guess_count_q, guess_count_d;
`ifdef MASTERMIND_SCORER_HINT_EN
  peg_mask_t          hint_exact_q, hint_exact_d;
`endif

  peg_mask_t          exact;
  peg_mask_t          used_base;
  peg_mask_t          match_sel;
  logic               match_found;
  logic               round_start;
  logic               compare_take;
  logic               publish;

  // Exact matches come straight from the registers, which stay frozen for
  // the whole round.
  always_comb begin
    exact = '0;
    for (int j = 0; j < NUM_PEGS; j++) begin
      exact[j] = (code_q[j] == guess_q[j]);
    end
  end

  // A compare of position 0 opens a new round unless position 0 was already
  // scored in the current round (a duplicate index). Other positions only
  // count inside an active round and only the first time they are seen.
  assign round_start  = compare && (compare_i == 2'd0) && (!done_q[0] || !round_active_q);
  assign compare_take = round_start || (compare && round_active_q && !done_q[compare_i]);
  assign publish      = reach_result_4 && !game_over;

  // The colour search must see the cleared used mask in the cycle a round
  // starts, since position 0 is scored in that same cycle.
  assign used_base = round_start ? '0 : used_q;

  peg_matcher #(
    .COLOR_W (COLOR_W)
  ) u_peg_matcher (
    .guess_color (guess_q[compare_i]),
    .code        (code_q),
    .exact_mask  (exact),
    .used_mask   (used_base),
    .found       (match_found),
    .match_sel   (match_sel)
  );

  // Next-state logic: loading, round start, per-position scoring, publish.
  // The publish step reads the already-updated accumulators so a compare
  // landing in the same cycle as reach_result_4 is included.
  always_comb begin
    code_d         = code_q;
    guess_d        = guess_q;
    used_d         = used_q;
    done_d         = done_q;
    round_active_d = round_active_q;
    acc_black_d    = acc_black_q;
    acc_white_d    = acc_white_q;
    black_d        = black_q;
    white_d        = white_q;
    result_valid_d = 1'b0;
    win_d          = win_q;
    guess_count_d  = guess_count_q;
`ifdef MASTERMIND_SCORER_HINT_EN
    hint_exact_d   = hint_exact_q;
`endif

    if (!round_active_q) begin
      if (load_code_1)  code_d[0]  = peg_in;
      if (load_code_2)  code_d[1]  = peg_in;
      if (load_code_3)  code_d[2]  = peg_in;
      if (load_code_4)  code_d[3]  = peg_in;
      if (load_guess_1) guess_d[0] = peg_in;
      if (load_guess_2) guess_d[1] = peg_in;
      if (load_guess_3) guess_d[2] = peg_in;
      if (load_guess_4) guess_d[3] = peg_in;
    end

    if (round_start) begin
      used_d         = '0;
      done_d         = '0;
      acc_black_d    = '0;
      acc_white_d    = '0;
      round_active_d = 1'b1;
    end

    if (compare_take) begin
      done_d[compare_i] = 1'b1;
      if (exact[compare_i]) begin
        acc_black_d = acc_black_d + score_t'(1);
      end else if (match_found) begin
        used_d      = used_d | match_sel;
        acc_white_d = acc_white_d + score_t'(1);
      end
    end

    if (publish) begin
      black_d        = acc_black_d;
      white_d        = acc_white_d;
      result_valid_d = 1'b1;
      if (guess_count_q != CNT_W'(MAX_GUESSES)) begin
        guess_count_d = guess_count_q + CNT_W'(1);
      end
      win_d          = win_q | (acc_black_d == score_t'(4));
      round_active_d = 1'b0;
`ifdef MASTERMIND_SCORER_HINT_EN
      hint_exact_d   = exact;
`endif
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      code_q         <= '0;
      guess_q        <= '0;
      used_q         <= '0;
      done_q         <= '0;
      round_active_q <= 1'b0;
      acc_black_q    <= '0;
      acc_white_q    <= '0;
      black_q        <= '0;
      white_q        <= '0;
      result_valid_q <= 1'b0;
      win_q          <= 1'b0;
      guess_count_q  <= '0;
`ifdef MASTERMIND_SCORER_HINT_EN
      hint_exact_q   <= '0;
`endif
    end else begin
      code_q         <= code_d;
      guess_q        <= guess_d;
      used_q         <= used_d;
      done_q         <= done_d;
      round_active_q <= round_active_d;
      acc_black_q    <= acc_black_d;
      acc_white_q    <= acc_white_d;
      black_q        <= black_d;
      white_q        <= white_d;
      result_valid_q <= result_valid_d;
      win_q          <= win_d;
      guess_count_q  <= guess_count_d;
`ifdef MASTERMIND_SCORER_HINT_EN
      hint_exact_q   <= hint_exact_d;
`endif
    end
  end

  assign black        = black_q;
  assign white        = white_q;
  assign result_valid = result_valid_q;
  assign win          = win_q;
  assign guess_count  = guess_count_q;
  assign game_over    = win_q || (guess_count_q == CNT_W'(MAX_GUESSES));
`ifdef MASTERMIND_SCORER_HINT_EN
  assign hint_exact   = hint_exact_q;
`endif

endmodule

// File: tb/tb_mastermind_scorer.sv
// tb_mastermind_scorer: table-driven directed bench for mastermind_scorer.
// Ten non-winning rounds run back to back to reach game over, followed by
// hand-written sequences for freeze, win, mid-round reset and the
// simultaneous compare/publish case.
module tb_mastermind_scorer;

  logic       clk;
  logic       reset;
  logic [2:0] peg_in;
  logic       load_code_1, load_code_2, load_code_3, load_code_4;
  logic       load_guess_1, load_guess_2, load_guess_3, load_guess_4;
  logic       compare;
  logic [1:0] compare_i;
  logic       reach_result_4;
  logic [2:0] black;
  logic [2:0] white;
  logic       result_valid;
  logic       win;
  logic       game_over;
  logic [3:0] guess_count;
`ifdef MASTERMIND_SCORER_HINT_EN
  logic [3:0] hint_exact;
`endif

  int vectors_applied = 0;
  int miscompares     = 0;

  // Order modes: 0 = positions 0,1,2,3; 1 = 0,1,1,2,3 (duplicate);
  // 2 = 3,2,1,0 (only 0 opens a round); 3 = 0,2,3 (position 1 skipped).
  typedef struct packed {
    logic [3:0][2:0] code;
    logic [3:0][2:0] guess;
    logic [1:0]      mode;
    logic [2:0]      exp_black;
    logic [2:0]      exp_white;
  } vec_t;

  vec_t vectors [10];

  mastermind_scorer #(
    .COLOR_W     (3),
    .MAX_GUESSES (10),
    .CNT_W       (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .peg_in         (peg_in),
    .load_code_1    (load_code_1),
    .load_code_2    (load_code_2),
    .load_code_3    (load_code_3),
    .load_code_4    (load_code_4),
    .load_guess_1   (load_guess_1),
    .load_guess_2   (load_guess_2),
    .load_guess_3   (load_guess_3),
    .load_guess_4   (load_guess_4),
    .compare        (compare),
    .compare_i      (compare_i),
    .reach_result_4 (reach_result_4),
    .black          (black),
    .white          (white),
    .result_valid   (result_valid),
    .win            (win),
    .game_over      (game_over),
    .guess_count    (guess_count)
`ifdef MASTERMIND_SCORER_HINT_EN
    ,
    .hint_exact     (hint_exact)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int c0, input int c1, input int c2, input int c3,
                              input int g0, input int g1, input int g2, input int g3,
                              input int mode, input int eb, input int ew);
    vec_t v;
    v.code[0]   = 3'(c0);
    v.code[1]   = 3'(c1);
    v.code[2]   = 3'(c2);
    v.code[3]   = 3'(c3);
    v.guess[0]  = 3'(g0);
    v.guess[1]  = 3'(g1);
    v.guess[2]  = 3'(g2);
    v.guess[3]  = 3'(g3);
    v.mode      = 2'(mode);
    v.exp_black = 3'(eb);
    v.exp_white = 3'(ew);
    return v;
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic loadCode(input logic [3:0][2:0] c);
    peg_in = c[0]; load_code_1 = 1'b1; step(); load_code_1 = 1'b0;
    peg_in = c[1]; load_code_2 = 1'b1; step(); load_code_2 = 1'b0;
    peg_in = c[2]; load_code_3 = 1'b1; step(); load_code_3 = 1'b0;
    peg_in = c[3]; load_code_4 = 1'b1; step(); load_code_4 = 1'b0;
  endtask

  task automatic loadGuess(input logic [3:0][2:0] g);
    peg_in = g[0]; load_guess_1 = 1'b1; step(); load_guess_1 = 1'b0;
    peg_in = g[1]; load_guess_2 = 1'b1; step(); load_guess_2 = 1'b0;
    peg_in = g[2]; load_guess_3 = 1'b1; step(); load_guess_3 = 1'b0;
    peg_in = g[3]; load_guess_4 = 1'b1; step(); load_guess_4 = 1'b0;
  endtask

  task automatic doCompare(input int i);
    compare = 1'b1;
    compare_i = 2'(i);
    step();
    compare = 1'b0;
    compare_i = 2'd0;
  endtask

  task automatic runOrder(input logic [1:0] mode);
    case (mode)
      2'd0: begin doCompare(0); doCompare(1); doCompare(2); doCompare(3); end
      2'd1: begin doCompare(0); doCompare(1); doCompare(1); doCompare(2); doCompare(3); end
      2'd2: begin doCompare(3); doCompare(2); doCompare(1); doCompare(0); end
      default: begin doCompare(0); doCompare(2); doCompare(3); end
    endcase
  endtask

  task automatic doPublish();
    reach_result_4 = 1'b1;
    step();
    reach_result_4 = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    loadCode(v.code);
    loadGuess(v.guess);
    runOrder(v.mode);
    doPublish();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_black"}, int'(black), 0);
    checkOutput({tag, "_white"}, int'(white), 0);
    checkOutput({tag, "_rv"}, int'(result_valid), 0);
    checkOutput({tag, "_win"}, int'(win), 0);
    checkOutput({tag, "_game_over"}, int'(game_over), 0);
    checkOutput({tag, "_guess_count"}, int'(guess_count), 0);
  endtask

  initial begin
    reset = 1'b1;
    peg_in = '0;
    load_code_1 = 0; load_code_2 = 0; load_code_3 = 0; load_code_4 = 0;
    load_guess_1 = 0; load_guess_2 = 0; load_guess_3 = 0; load_guess_4 = 0;
    compare = 0; compare_i = '0; reach_result_4 = 0;

    vectors[0] = mk(1,2,3,4, 4,3,2,1, 0, 0,4);
    vectors[1] = mk(1,1,2,2, 1,2,1,3, 0, 1,2);
    vectors[2] = mk(3,3,0,7, 3,0,7,3, 0, 1,3);
    vectors[3] = mk(6,6,6,6, 7,7,7,7, 0, 0,0);
    vectors[4] = mk(5,5,5,5, 5,0,0,0, 1, 1,0);
    vectors[5] = mk(1,2,3,4, 1,2,3,4, 2, 1,0);
    vectors[6] = mk(1,2,3,4, 2,1,3,4, 3, 2,1);
    vectors[7] = mk(1,0,0,0, 0,1,1,1, 0, 0,2);
    vectors[8] = mk(7,6,5,4, 6,7,4,5, 0, 0,4);
    vectors[9] = mk(2,4,2,4, 4,2,4,2, 0, 0,4);

    step(); step();
    reset = 1'b0;
    checkAllZero("reset");

    // Ten scored rounds, none a win.
    for (int n = 0; n < 10; n++) begin
      applyStimulus(vectors[n]);
      checkOutput($sformatf("v%0d_black", n), int'(black), int'(vectors[n].exp_black));
      checkOutput($sformatf("v%0d_white", n), int'(white), int'(vectors[n].exp_white));
      checkOutput($sformatf("v%0d_rv_high", n), int'(result_valid), 1);
      checkOutput($sformatf("v%0d_guess_count", n), int'(guess_count), n + 1);
      checkOutput($sformatf("v%0d_win", n), int'(win), 0);
      step();
      checkOutput($sformatf("v%0d_rv_low", n), int'(result_valid), 0);
    end
    checkOutput("limit_game_over", int'(game_over), 1);

    // Eleventh round would be a win, but game over blocks publishing.
    loadCode(12'h0);
    loadGuess(12'h0);
    runOrder(2'd0);
    doPublish();
    checkOutput("over_rv", int'(result_valid), 0);
    checkOutput("over_black", int'(black), 0);
    checkOutput("over_white", int'(white), 4);
    checkOutput("over_win", int'(win), 0);
    checkOutput("over_guess_count", int'(guess_count), 10);

    reset = 1'b1; step(); reset = 1'b0;
    checkAllZero("reset2");

    // Loads during an active round are ignored; exact code wins.
    loadCode({3'd4, 3'd3, 3'd2, 3'd1});
    loadGuess({3'd4, 3'd3, 3'd2, 3'd1});
    doCompare(0);
    peg_in = 3'd7; load_guess_2 = 1'b1; load_code_3 = 1'b1;
    step();
    load_guess_2 = 1'b0; load_code_3 = 1'b0;
    doCompare(1); doCompare(2); doCompare(3);
    doPublish();
    checkOutput("win_black", int'(black), 4);
    checkOutput("win_white", int'(white), 0);
    checkOutput("win_rv_high", int'(result_valid), 1);
    checkOutput("win_win", int'(win), 1);
    checkOutput("win_game_over", int'(game_over), 1);
    checkOutput("win_guess_count", int'(guess_count), 1);
    step();
    checkOutput("win_rv_low", int'(result_valid), 0);
    doPublish();
    checkOutput("win_after_rv", int'(result_valid), 0);
    checkOutput("win_after_guess_count", int'(guess_count), 1);

    // Reset in the middle of a round.
    reset = 1'b1; step(); reset = 1'b0;
    loadCode({3'd4, 3'd3, 3'd2, 3'd1});
    loadGuess({3'd4, 3'd3, 3'd2, 3'd1});
    doCompare(0); doCompare(1);
    reset = 1'b1; step(); reset = 1'b0;
    checkAllZero("midreset");

    applyStimulus(mk(2,2,2,2, 2,2,3,3, 0, 2,0));
    checkOutput("fresh_black", int'(black), 2);
    checkOutput("fresh_white", int'(white), 0);
    checkOutput("fresh_rv", int'(result_valid), 1);
    checkOutput("fresh_win", int'(win), 0);
    checkOutput("fresh_guess_count", int'(guess_count), 1);

    // Last compare lands in the publish cycle and must be counted.
    loadCode({3'd1, 3'd1, 3'd1, 3'd1});
    loadGuess({3'd1, 3'd2, 3'd2, 3'd1});
    doCompare(0); doCompare(1); doCompare(2);
    compare = 1'b1; compare_i = 2'd3; reach_result_4 = 1'b1;
    step();
    compare = 1'b0; compare_i = 2'd0; reach_result_4 = 1'b0;
    checkOutput("simul_black", int'(black), 2);
    checkOutput("simul_white", int'(white), 0);
    checkOutput("simul_rv", int'(result_valid), 1);
    checkOutput("simul_guess_count", int'(guess_count), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule

// File: doc/mastermind_scorer.md
Name: mastermind_scorer

Overview:
Datapath responder to the game controller's strobe protocol. It captures code and guess pegs on the controller's load strobes and scores one guess position per `compare`/`compare_i` cycle. On `reach_result_4` it publishes black (exact) and white (colour-only) peg counts, plus win and game-over status. It sits between the switch/key input and the LEDR/HEX result display.

Parameters:
COLOR_W, 3, bits per peg colour.
MAX_GUESSES, 10, number of scored rounds before `game_over`.
CNT_W, 4, width of `guess_count`; must satisfy 2^CNT_W > MAX_GUESSES.

Ports:
clk  in  1  system clock; single clock domain.
reset  in  1  synchronous, active-high reset.
peg_in  in  COLOR_W  colour value from switches.
load_code_1..load_code_4  in  1 each  level strobes from controller; write code slot 0..3.
load_guess_1..load_guess_4  in  1 each  level strobes; write guess slot 0..3.
compare  in  1  score one position this cycle.
compare_i  in  2  position index being scored.
reach_result_4  in  1  round complete; publish score.
black  out  3  exact matches of last published round (0..4).
white  out  3  colour-only matches of last published round (0..4).
result_valid  out  1  one-cycle pulse when black/white update.
win  out  1  sticky; set when a published black==4.
game_over  out  1  sticky; win OR guess_count==MAX_GUESSES.
guess_count  out  CNT_W  rounds published since reset.

Behaviour:
- Reset values:
  - All outputs are 0.
  - code[0..3] and guess[0..3] are 0.
  - Internal `used`, `done` and round_active are 0; accumulators are 0.
- Loading:
  - While `load_code_k` is high at a posedge, code[k-1] <= peg_in. Guess slots load the same way from `load_guess_k`.
  - Strobes are levels, so the last cycle the strobe is high wins.
  - While round_active=1, load strobes are ignored and registers are frozen.
- `exact[j]` = (code[j]==guess[j]). It is combinational from the frozen registers.
- Round start:
  - Trigger: `compare` high with compare_i==0 while `done[0]`==0 or round_active==0.
  - The accumulators, `used` and `done` are cleared, round_active <= 1, and position 0 is processed in that same cycle.
- Compare cycle, position i=compare_i:
  - If `done[i]`==1, the cycle is ignored, so duplicate indices do not double count. Otherwise `done[i]` <= 1.
  - If `exact[i]`, then acc_black += 1.
  - Otherwise, search for the lowest j with !`exact[j]` && !`used[j]` && code[j]==guess[i]. If one is found, `used[j]` <= 1 and acc_white += 1. If none is found, there is no change.
  - This greedy order yields white = sum over colours of min(count_code, count_guess) − black.
- `compare` with round_active==0 and compare_i!=0 is ignored.
- Publish, on a `reach_result_4` posedge with game_over==0:
  - black <= acc_black; white <= acc_white.
  - result_valid is asserted the next cycle, for exactly 1 cycle.
  - guess_count saturates at MAX_GUESSES.
  - win <= win | (acc_black==4).
  - round_active <= 0.
  - Positions not yet compared contribute nothing.
- With game_over==1, `reach_result_4` is ignored: outputs hold and result_valid stays 0.
- Simultaneous `compare` and `reach_result_4`: the compare contribution is included in the published value. The controller never does this; the rule is defined for determinism only.
- Mid-operation reset returns everything to reset values on the next edge.
- Latency: `reach_result_4` edge to black/white/result_valid valid is 1 cycle.
- Counter widths: the 3-bit counters never exceed 4.

Optional Feature:
MASTERMIND_SCORER_HINT_EN.
- Defined: adds output `hint_exact` [3:0], registered copy of `exact` at publish, reset 0, updating with result_valid.
- Undefined: port and register are absent; behaviour is otherwise identical.

Decomposition:
- Package mm_pkg holds:
  - NUM_PEGS=4 and COLOR_W.
  - typedef color_t [COLOR_W-1:0].
  - typedef score_t [2:0].
  - typedef peg_mask_t [3:0].
- One combinational sub-module, peg_matcher:
  - Inputs: guess colour, code array, exact mask, used mask.
  - Outputs: found and one-hot match select.

Test Plan:
- code 1,2,3,4; guess 1,2,3,4; compare 0..3; `reach_result_4` → next cycle black=4, white=0, result_valid=1 for 1 cycle, win=1, game_over=1.
- code 1,2,3,4; guess 4,3,2,1 → black=0, white=4, win=0, guess_count=1.
- code 1,1,2,2; guess 1,2,1,3 → black=1, white=2. The duplicate `used` bookkeeping is checked via white not exceeding 2.
- code 5,5,5,5; guess 5,0,0,0; compare_i sequence 0,1,1,2,3 (duplicate) → black=1, white=0.
- Game-over and freeze:
  - Ten rounds with black<4 → guess_count=10, game_over=1, win=0.
  - 11th `reach_result_4` → result_valid stays 0, outputs unchanged.
  - `load_guess_2` asserted during a round → guess[1] is unchanged.
- Mid-round reset:
  - Assert reset after compare_i=1 → all outputs 0.
  - A fresh round with code 2,2,2,2 and guess 2,2,3,3 → black=2, white=0.
